// File: rtl/baccarat_dealer.sv
// Round sequencer for one baccarat hand: loads six card registers from the card
// source on step pulses and applies the third-card rules using external scorehand totals.
module baccarat_dealer (
    input  logic       slow_clock,
    input  logic       reset,
    input  logic       step,
    input  logic [3:0] new_card,
    input  logic [3:0] pscore,
    input  logic [3:0] dscore,
    output logic [3:0] pcard1,
    output logic [3:0] pcard2,
    output logic [3:0] pcard3,
    output logic [3:0] dcard1,
    output logic [3:0] dcard2,
    output logic [3:0] dcard3,
    output logic       player_win,
    output logic       dealer_win,
    output logic       done,
    output logic [3:0] state_dbg
);

    typedef enum logic [3:0] {
        DEAL_P1 = 4'd0,
        DEAL_D1 = 4'd1,
        DEAL_P2 = 4'd2,
        DEAL_D2 = 4'd3,
        EVAL    = 4'd4,
        DEAL_P3 = 4'd5,
        EVAL_D  = 4'd6,
        DEAL_D3 = 4'd7,
        DONE    = 4'd8
    } state_t;

    state_t state, state_next;

    logic [3:0] third_value;
    logic       dealer_draws;

    // Face cards and tens count as zero.
    function automatic logic [3:0] card_value(input logic [3:0] c);
        if (c >= 4'd1 && c <= 4'd9) begin
            card_value = c;
        end else begin
            card_value = 4'd0;
        end
    endfunction

    always_ff @(posedge slow_clock) begin
        if (reset) begin
            state  <= DEAL_P1;
            pcard1 <= 4'd0;
            pcard2 <= 4'd0;
            pcard3 <= 4'd0;
            dcard1 <= 4'd0;
            dcard2 <= 4'd0;
            dcard3 <= 4'd0;
        end else begin
            state <= state_next;
            if (step) begin
                case (state)
                    DEAL_P1: pcard1 <= new_card;
                    DEAL_D1: dcard1 <= new_card;
                    DEAL_P2: pcard2 <= new_card;
                    DEAL_D2: dcard2 <= new_card;
                    DEAL_P3: pcard3 <= new_card;
                    DEAL_D3: dcard3 <= new_card;
                    default: ;
                endcase
            end
        end
    end

    // Dealer third-card table, indexed by dealer total and the player's third card value.
    always_comb begin
        third_value  = card_value(pcard3);
        dealer_draws = 1'b0;
        case (dscore)
            4'd0, 4'd1, 4'd2: dealer_draws = 1'b1;
            4'd3:             dealer_draws = (third_value != 4'd8);
            4'd4:             dealer_draws = (third_value >= 4'd2) && (third_value <= 4'd7);
            4'd5:             dealer_draws = (third_value >= 4'd4) && (third_value <= 4'd7);
            4'd6:             dealer_draws = (third_value >= 4'd6) && (third_value <= 4'd7);
            default:          dealer_draws = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        if (step) begin
            case (state)
                DEAL_P1: state_next = DEAL_D1;
                DEAL_D1: state_next = DEAL_P2;
                DEAL_P2: state_next = DEAL_D2;
                DEAL_D2: state_next = EVAL;
                EVAL: begin
                    if (pscore >= 4'd8 || dscore >= 4'd8) begin
                        state_next = DONE;
                    end else if (pscore <= 4'd5) begin
                        state_next = DEAL_P3;
                    end else if (dscore <= 4'd5) begin
                        state_next = DEAL_D3;
                    end else begin
                        state_next = DONE;
                    end
                end
                DEAL_P3: state_next = EVAL_D;
                EVAL_D:  state_next = dealer_draws ? DEAL_D3 : DONE;
                DEAL_D3: state_next = DONE;
                DONE:    state_next = DONE;
                default: state_next = DEAL_P1;
            endcase
        end
    end

    always_comb begin
        done       = (state == DONE);
        player_win = done && (pscore >= dscore);
        dealer_win = done && (dscore >= pscore);
        state_dbg  = state;
    end

endmodule

// File: tb/tb_baccarat_dealer.sv
// Directed bench for baccarat_dealer: models the two scorehand blocks, plays fixed
// rounds, and checks final hands and win flags through an expected-result queue.
module tb_baccarat_dealer;

    logic       slow_clock;
    logic       reset;
    logic       step;
    logic [3:0] new_card;
    logic [3:0] pscore;
    logic [3:0] dscore;
    logic [3:0] pcard1, pcard2, pcard3;
    logic [3:0] dcard1, dcard2, dcard3;
    logic       player_win, dealer_win, done;
    logic [3:0] state_dbg;

    int compared   = 0;
    int mismatched = 0;

    // Result word: {pcard1,pcard2,pcard3,dcard1,dcard2,dcard3,player_win,dealer_win}
    logic [25:0] exp_q[$];

    baccarat_dealer dut (
        .slow_clock (slow_clock),
        .reset      (reset),
        .step       (step),
        .new_card   (new_card),
        .pscore     (pscore),
        .dscore     (dscore),
        .pcard1     (pcard1),
        .pcard2     (pcard2),
        .pcard3     (pcard3),
        .dcard1     (dcard1),
        .dcard2     (dcard2),
        .dcard3     (dcard3),
        .player_win (player_win),
        .dealer_win (dealer_win),
        .done       (done),
        .state_dbg  (state_dbg)
    );

    // Clock / reset block
    initial slow_clock = 1'b0;
    always #5 slow_clock = ~slow_clock;

    // External scorehand model
    function automatic int val(input logic [3:0] c);
        return (c >= 4'd1 && c <= 4'd9) ? int'(c) : 0;
    endfunction

    always_comb begin
        pscore = 4'((val(pcard1) + val(pcard2) + val(pcard3)) % 10);
        dscore = 4'((val(dcard1) + val(dcard2) + val(dcard3)) % 10);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Driver tasks: inputs change on the falling edge, DUT samples on the rising edge.
    task automatic do_reset(input logic with_step, input logic [3:0] card);
        @(negedge slow_clock);
        reset    = 1'b1;
        step     = with_step;
        new_card = card;
        @(negedge slow_clock);
        reset    = 1'b0;
        step     = 1'b0;
        new_card = 4'd0;
    endtask

    task automatic do_step(input logic [3:0] card);
        @(negedge slow_clock);
        step     = 1'b1;
        new_card = card;
        @(negedge slow_clock);
        step     = 1'b0;
        new_card = 4'd0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge slow_clock);
            n++;
        end
        if (done !== 1'b1) begin
            compared++;
            mismatched++;
            $error("FAIL %s_timeout observed done=%b expected=1", tag, done);
        end
    endtask

    // Scoreboard: pop the oldest expectation and compare against the DUT's final hand.
    task automatic check_result(input string tag);
        logic [25:0] e;
        if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $error("FAIL %s_empty_queue observed=0 expected=1", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_pcard1"}, 32'(pcard1), 32'(e[25:22]));
            chk({tag, "_pcard2"}, 32'(pcard2), 32'(e[21:18]));
            chk({tag, "_pcard3"}, 32'(pcard3), 32'(e[17:14]));
            chk({tag, "_dcard1"}, 32'(dcard1), 32'(e[13:10]));
            chk({tag, "_dcard2"}, 32'(dcard2), 32'(e[9:6]));
            chk({tag, "_dcard3"}, 32'(dcard3), 32'(e[5:2]));
            chk({tag, "_player_win"}, 32'(player_win), 32'(e[1]));
            chk({tag, "_dealer_win"}, 32'(dealer_win), 32'(e[0]));
            chk({tag, "_done"}, 32'(done), 32'd1);
        end
    endtask

    task automatic deal_four(input logic [3:0] p1, input logic [3:0] d1,
                             input logic [3:0] p2, input logic [3:0] d2);
        do_step(p1);
        do_step(d1);
        do_step(p2);
        do_step(d2);
    endtask

    initial begin
        reset    = 1'b0;
        step     = 1'b0;
        new_card = 4'd0;

        // Reset with step high: the step must be discarded.
        do_reset(1'b1, 4'd7);
        chk("rst_pcard1", 32'(pcard1), 32'd0);
        chk("rst_dcard1", 32'(dcard1), 32'd0);
        chk("rst_pcard3", 32'(pcard3), 32'd0);
        chk("rst_dcard3", 32'(dcard3), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_player_win", 32'(player_win), 32'd0);
        chk("rst_dealer_win", 32'(dealer_win), 32'd0);
        chk("rst_state", 32'(state_dbg), 32'd0);
        do_step(4'd5);
        chk("first_pcard1", 32'(pcard1), 32'd5);
        chk("first_dcard1", 32'(dcard1), 32'd0);
        chk("first_pcard2", 32'(pcard2), 32'd0);

        // Natural: p9 d5 after four cards.
        do_reset(1'b0, 4'd0);
        exp_q.push_back({4'd9, 4'd10, 4'd0, 4'd2, 4'd3, 4'd0, 1'b1, 1'b0});
        deal_four(4'd9, 4'd2, 4'd10, 4'd3);
        chk("natural_not_done_early", 32'(done), 32'd0);
        chk("natural_no_win_early", 32'({player_win, dealer_win}), 32'd0);
        do_step(4'd0);
        wait_done("natural");
        check_result("natural");

        // Player draws 6, dealer on 6 draws, ends p9 d7.
        do_reset(1'b0, 4'd0);
        exp_q.push_back({4'd2, 4'd1, 4'd6, 4'd3, 4'd3, 4'd1, 1'b1, 1'b0});
        deal_four(4'd2, 4'd3, 4'd1, 4'd3);
        do_step(4'd0);
        chk("pdraw_state_p3", 32'(state_dbg), 32'd5);
        do_step(4'd6);
        do_step(4'd0);
        chk("pdraw_state_d3", 32'(state_dbg), 32'd7);
        do_step(4'd1);
        wait_done("pdraw");
        check_result("pdraw");

        // Player stands on 7, dealer draws from 4 to 7: tie.
        do_reset(1'b0, 4'd0);
        exp_q.push_back({4'd3, 4'd4, 4'd0, 4'd2, 4'd2, 4'd3, 1'b1, 1'b1});
        deal_four(4'd3, 4'd2, 4'd4, 4'd2);
        do_step(4'd0);
        do_step(4'd3);
        wait_done("pstand");
        check_result("pstand");

        // Dealer on 3 stands when the player's third card is 8.
        do_reset(1'b0, 4'd0);
        exp_q.push_back({4'd1, 4'd1, 4'd8, 4'd1, 4'd2, 4'd0, 1'b0, 1'b1});
        deal_four(4'd1, 4'd1, 4'd1, 4'd2);
        do_step(4'd0);
        do_step(4'd8);
        do_step(4'd0);
        wait_done("d3stand");
        check_result("d3stand");

        // Both stand on 6: tie after five steps, face card in the hand.
        do_reset(1'b0, 4'd0);
        exp_q.push_back({4'd3, 4'd3, 4'd0, 4'd13, 4'd6, 4'd0, 1'b1, 1'b1});
        deal_four(4'd3, 4'd13, 4'd3, 4'd6);
        do_step(4'd0);
        wait_done("both_stand");
        check_result("both_stand");

        // Reset mid-round in DEAL_P3, with a step on the same edge.
        do_reset(1'b0, 4'd0);
        deal_four(4'd2, 4'd3, 4'd1, 4'd3);
        do_step(4'd0);
        chk("mid_state_p3", 32'(state_dbg), 32'd5);
        do_reset(1'b1, 4'd9);
        chk("mid_rst_state", 32'(state_dbg), 32'd0);
        chk("mid_rst_pcard1", 32'(pcard1), 32'd0);
        chk("mid_rst_dcard2", 32'(dcard2), 32'd0);
        chk("mid_rst_pcard3", 32'(pcard3), 32'd0);

        // Complete a round, then step three times in DONE: nothing may change.
        exp_q.push_back({4'd3, 4'd4, 4'd0, 4'd2, 4'd2, 4'd3, 1'b1, 1'b1});
        exp_q.push_back({4'd3, 4'd4, 4'd0, 4'd2, 4'd2, 4'd3, 1'b1, 1'b1});
        deal_four(4'd3, 4'd2, 4'd4, 4'd2);
        do_step(4'd0);
        do_step(4'd3);
        wait_done("hold");
        check_result("hold_before");
        for (int i = 0; i < 3; i++) begin
            do_step(4'($urandom_range(1, 13)));
        end
        check_result("hold_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
